wb_cmd_master: RTL

- Wishbone B4 classic single-transfer initiator that drives the UART register-slave port: address 0 = TX data (write), address 1 = RX data (read).
- Converts a valid/ready command stream from a host-side sequencer (test harness, soft-CPU bridge, loopback engine) into one STB/ACK bus cycle per command.
- Returns a response (read data plus error flag) on a valid/ready response channel.
- Exactly one transaction in flight; no pipelining.

---
 rtl/wb_cmd_master_pkg.sv | 17 +
 rtl/wb_cmd_timeout.sv | 44 ++++
 rtl/wb_cmd_master.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wb_cmd_master_pkg.sv
// rtl/wb_cmd_master_pkg.sv - shared types and register map for the Wishbone command master
// Contents:
//   state_t  : bus-cycle FSM states (IDLE, BUS, RSP)
//   ADDR_TX  : UART register-slave TX data address (write)
//   ADDR_RX  : UART register-slave RX data address (read)
package wb_cmd_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RSP  = 2'd2
    } state_t;

    localparam logic ADDR_TX = 1'b0;
    localparam logic ADDR_RX = 1'b1;

endpackage

// File: rtl/wb_cmd_timeout.sv
// rtl/wb_cmd_timeout.sv - bus-cycle watchdog counter with expiry flag
// Used only when WB_CMD_MASTER_TIMEOUT_EN is defined.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clear        : hold the count at zero (asserted whenever the master is outside BUS)
//   i_run          : count this cycle (master in BUS with no ACK)
//   o_expired      : count has reached G_TIMEOUT-1
module wb_cmd_timeout #(
    parameter int G_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int                CNT_W    = $clog2(G_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(G_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_expired = (cnt_q == CNT_LAST);

    // Saturate at the last value so a held expiry never wraps back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_run && !o_expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - Wishbone B4 classic single-transfer initiator driven by a command stream
// Optional feature macro: WB_CMD_MASTER_TIMEOUT_EN (abort a bus cycle after G_TIMEOUT cycles without ACK).
// Ports:
//   i_clk, i_rst_n                          : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_cmd_we/addr/data : command channel (o_cmd_ready is combinational)
//   o_rsp_valid/i_rsp_ready, o_rsp_data/err : response channel
//   o_cyc, o_stb, o_we, o_addr, o_data      : Wishbone initiator outputs (registered)
//   i_data, i_ack                           : Wishbone read data and acknowledge
module wb_cmd_master
    import wb_cmd_master_pkg::*;
#(
    parameter int G_WORD_WIDTH = 8,
    parameter int G_ADDR_WIDTH = 1,
    parameter int G_TIMEOUT    = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_we,
    input  logic [G_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [G_WORD_WIDTH-1:0] i_cmd_data,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [G_WORD_WIDTH-1:0] o_rsp_data,
    output logic                    o_rsp_err,
    output logic                    o_cyc,
    output logic                    o_stb,
    output logic                    o_we,
    output logic [G_ADDR_WIDTH-1:0] o_addr,
    output logic [G_WORD_WIDTH-1:0] o_data,
    input  logic [G_WORD_WIDTH-1:0] i_data,
    input  logic                    i_ack
);

    if (G_TIMEOUT < 2) begin : g_timeout_check
        $error("wb_cmd_master: G_TIMEOUT must be at least 2");
    end

    state_t                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [G_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [G_WORD_WIDTH-1:0] data_q, data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [G_WORD_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
    // Counter is held clear outside BUS, so it always starts from zero on BUS entry.
    wb_cmd_timeout #(
        .G_TIMEOUT (G_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (state_q != BUS),
        .i_run     ((state_q == BUS) && !i_ack),
        .o_expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign o_cmd_ready = (state_q == IDLE);
    assign o_cyc       = cyc_q;
    assign o_stb       = stb_q;
    assign o_we        = we_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;

    // i_ack is only looked at in BUS; the slave's trailing ACK lands in RSP and is dropped.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    data_d  = i_cmd_data;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // ACK takes priority over a simultaneous timeout expiry.
                if (i_ack) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_data_d  = we_q ? '0 : i_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
